// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller with per-line mask, level/edge mode and a
// fixed-priority vector register. Define INTCTL_POLARITY_EN to build the POL register.
module int_ctrl #(
    parameter int NUM_LINES = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [NUM_LINES-1:0] irq_i,
    input  logic [3:0]           A_i,
    input  logic [7:0]           D_i,
    output logic [7:0]           D_o,
    input  logic                 rd_i,
    input  logic                 wr_i,
    output logic                 n_int_o
);

    localparam int W = NUM_LINES;

    typedef enum logic [3:0] {
        ADDR_STATUS = 4'd0,
        ADDR_PEND   = 4'd1,
        ADDR_MASK   = 4'd2,
        ADDR_MODE   = 4'd3,
        ADDR_VECTOR = 4'd4,
        ADDR_POL    = 4'd5
    } reg_addr_e;

    logic [W-1:0] sync1, sync2, sync3;
    logic [W-1:0] pend, mask, mode, pol_eff;
    logic [W-1:0] act, act_prev, rise, status, clear, pend_next;
    logic         wr_q, rd_q, wr_edge, rd_edge;
    logic [2:0]   vec_idx;
    logic         vec_valid;
    logic [7:0]   vector, rd_data;

    assign wr_edge  = wr_i & ~wr_q;
    assign rd_edge  = rd_i & ~rd_q;
    assign act      = sync2 ^ pol_eff;
    assign act_prev = sync3 ^ pol_eff;
    assign rise     = act & ~act_prev;
    assign status   = pend & mask;

    // Scan from the top so the lowest set index is the last one assigned.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        vec_idx = 3'd0;
        for (int i = W - 1; i >= 0; i--) begin
            if (status[i]) vec_idx = 3'(i);
        end
    end

    assign vec_valid = |status;
    assign vector    = vec_valid ? {1'b1, 4'b0000, vec_idx} : 8'h00;

    always_comb begin
        clear = '0;
        if (wr_edge && A_i == ADDR_PEND)
            clear = D_i[W-1:0];
        if (rd_edge && A_i == ADDR_VECTOR && vec_valid)
            clear = clear | (W'(1) << vec_idx);
    end

    // Edge lines: a new edge beats a simultaneous clear. Level lines follow act.
    assign pend_next = (mode & (rise | (pend & ~clear))) | (~mode & act);

    always_comb begin
        rd_data = 8'h00;
        case (A_i)
            ADDR_STATUS: rd_data = 8'(status);
            ADDR_PEND:   rd_data = 8'(pend);
            ADDR_MASK:   rd_data = 8'(mask);
            ADDR_MODE:   rd_data = 8'(mode);
            ADDR_VECTOR: rd_data = vector;
`ifdef INTCTL_POLARITY_EN
            ADDR_POL:    rd_data = 8'(pol_eff);
`endif
            default:     rd_data = 8'h00;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1   <= '0;
            sync2   <= '0;
            sync3   <= '0;
            pend    <= '0;
            mask    <= '0;
            mode    <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            D_o     <= 8'h00;
            n_int_o <= 1'b1;
        end else begin
            sync1   <= irq_i;
            sync2   <= sync1;
            sync3   <= sync2;
            pend    <= pend_next;
            wr_q    <= wr_i;
            rd_q    <= rd_i;
            n_int_o <= ~|status;
            if (rd_edge)
                D_o <= rd_data;
            if (wr_edge) begin
                case (A_i)
                    ADDR_MASK: mask <= D_i[W-1:0];
                    ADDR_MODE: mode <= D_i[W-1:0];
                    default:   ;
                endcase
            end
        end
    end

`ifdef INTCTL_POLARITY_EN
    logic [W-1:0] pol;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            pol <= '0;
        else if (wr_edge && A_i == ADDR_POL)
            pol <= D_i[W-1:0];
    end

    assign pol_eff = pol;
`else
    assign pol_eff = '0;
`endif

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed bench for int_ctrl with a cycle-level reference model
// and per-cycle comparison of D_o and n_int_o, plus literal register checks.
module tb_int_ctrl;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic [7:0] irq_i = 8'h00;
    logic [3:0] A_i = 4'd0;
    logic [7:0] D_i = 8'h00;
    logic [7:0] D_o;
    logic       rd_i = 1'b0;
    logic       wr_i = 1'b0;
    logic       n_int_o;

    int vectors = 0;
    int miscompares = 0;

    int_ctrl #(.NUM_LINES(8)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .irq_i   (irq_i),
        .A_i     (A_i),
        .D_i     (D_i),
        .D_o     (D_o),
        .rd_i    (rd_i),
        .wr_i    (wr_i),
        .n_int_o (n_int_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: irq history by age, register contents, expected outputs.
    logic [7:0] m_irq_age1, m_irq_age2, m_irq_age3;
    logic [7:0] m_pend, m_mask, m_mode, m_pol, m_dout;
    logic       m_nint, m_wr_prev, m_rd_prev;
    bit         model_valid = 0;

    function automatic logic [7:0] model_read(input logic [3:0] addr);
        logic [7:0] st, lowest;
        st = m_pend & m_mask;
        lowest = st & (~st + 8'd1);
        case (addr)
            4'd0: return st;
            4'd1: return m_pend;
            4'd2: return m_mask;
            4'd3: return m_mode;
            4'd4: return (st == 8'h00) ? 8'h00 : (8'h80 | 8'($clog2(lowest)));
            4'd5: return m_pol;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk_i) begin
        logic [7:0] st, clr, act_now, act_old, new_pend, rv;
        logic wr_e, rd_e;
        if (reset_i) begin
            m_irq_age1 = 0; m_irq_age2 = 0; m_irq_age3 = 0;
            m_pend = 0; m_mask = 0; m_mode = 0; m_pol = 0;
            m_dout = 8'h00; m_nint = 1'b1;
            m_wr_prev = 0; m_rd_prev = 0;
            model_valid = 1;
        end else if (model_valid) begin
            st   = m_pend & m_mask;
            wr_e = wr_i && !m_wr_prev;
            rd_e = rd_i && !m_rd_prev;
            rv   = model_read(A_i);
            clr  = 8'h00;
            if (wr_e && A_i == 4'd1) clr = D_i;
            if (rd_e && A_i == 4'd4 && st != 0) clr = clr | (st & (~st + 8'd1));
            act_now = m_irq_age2 ^ m_pol;
            act_old = m_irq_age3 ^ m_pol;
            for (int i = 0; i < 8; i++) begin
                if (!m_mode[i])                     new_pend[i] = act_now[i];
                else if (act_now[i] && !act_old[i]) new_pend[i] = 1'b1;
                else if (clr[i])                    new_pend[i] = 1'b0;
                else                                new_pend[i] = m_pend[i];
            end
            m_nint = (st == 8'h00);
            if (rd_e) m_dout = rv;
            if (wr_e && A_i == 4'd2) m_mask = D_i;
            if (wr_e && A_i == 4'd3) m_mode = D_i;
`ifdef INTCTL_POLARITY_EN
            if (wr_e && A_i == 4'd5) m_pol = D_i;
`endif
            m_pend = new_pend;
            m_irq_age3 = m_irq_age2;
            m_irq_age2 = m_irq_age1;
            m_irq_age1 = irq_i;
            m_wr_prev = wr_i;
            m_rd_prev = rd_i;
        end
    end

    always @(negedge clk_i) begin
        if (model_valid) begin
            check("model d_o", D_o, m_dout);
            check("model n_int_o", {7'b0, n_int_o}, {7'b0, m_nint});
        end
    end

    task automatic bus_write(input logic [3:0] addr, input logic [7:0] data);
        @(negedge clk_i);
        A_i = addr; D_i = data; wr_i = 1'b1;
        @(negedge clk_i);
        wr_i = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [7:0] data);
        @(negedge clk_i);
        A_i = addr; rd_i = 1'b1;
        @(negedge clk_i);
        rd_i = 1'b0;
        data = D_o;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        irq_i = 8'h00; reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        wait_cycles(2);
        reset_i = 1'b0;
        check("reset n_int_o", {7'b0, n_int_o}, 8'h01);
        check("reset d_o", D_o, 8'h00);

        // Level mode latency on line 0
        bus_write(4'd2, 8'h01);
        @(negedge clk_i) irq_i[0] = 1'b1;
        wait_cycles(3);
        check("level n_int after E2", {7'b0, n_int_o}, 8'h01);
        wait_cycles(1);
        check("level n_int after E3", {7'b0, n_int_o}, 8'h00);
        bus_read(4'd0, rd);
        check("level status", rd, 8'h01);
        @(negedge clk_i) irq_i[0] = 1'b0;
        wait_cycles(3);
        check("level drop n_int after E2", {7'b0, n_int_o}, 8'h00);
        wait_cycles(1);
        check("level drop n_int after E3", {7'b0, n_int_o}, 8'h01);
        bus_write(4'd1, 8'h01);
        wait_cycles(2);

        // Edge priority
        do_reset();
        bus_write(4'd3, 8'hFF);
        bus_write(4'd2, 8'h0C);
        @(negedge clk_i) irq_i = 8'h0C;
        wait_cycles(2);
        irq_i = 8'h00;
        wait_cycles(4);
        check("edge n_int pending", {7'b0, n_int_o}, 8'h00);
        bus_read(4'd4, rd);
        check("vector first", rd, 8'h82);
        wait_cycles(1);
        check("n_int after first ack", {7'b0, n_int_o}, 8'h00);
        bus_read(4'd4, rd);
        check("vector second", rd, 8'h83);
        wait_cycles(1);
        check("n_int after second ack", {7'b0, n_int_o}, 8'h01);
        bus_read(4'd4, rd);
        check("vector empty", rd, 8'h00);

        // Masked line
        do_reset();
        bus_write(4'd3, 8'hFF);
        @(negedge clk_i) irq_i[5] = 1'b1;
        wait_cycles(2);
        irq_i[5] = 1'b0;
        wait_cycles(4);
        bus_read(4'd1, rd);
        check("masked pend", rd, 8'h20);
        bus_read(4'd0, rd);
        check("masked status", rd, 8'h00);
        check("masked n_int", {7'b0, n_int_o}, 8'h01);
        bus_write(4'd2, 8'h20);
        check("unmask n_int same", {7'b0, n_int_o}, 8'h01);
        wait_cycles(1);
        check("unmask n_int next", {7'b0, n_int_o}, 8'h00);

        // Set/clear collision on line 1
        do_reset();
        bus_write(4'd3, 8'h02);
        bus_write(4'd2, 8'h02);
        @(negedge clk_i) irq_i[1] = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i) begin A_i = 4'd1; D_i = 8'h02; wr_i = 1'b1; end
        @(negedge clk_i) wr_i = 1'b0;
        wait_cycles(2);
        bus_read(4'd1, rd);
        check("collision pend", rd, 8'h02);
        check("collision n_int", {7'b0, n_int_o}, 8'h00);
        irq_i[1] = 1'b0;

        // Held read strobe acknowledges once
        do_reset();
        bus_write(4'd3, 8'hFF);
        bus_write(4'd2, 8'hFF);
        @(negedge clk_i) irq_i = 8'h03;
        wait_cycles(2);
        irq_i = 8'h00;
        wait_cycles(4);
        @(negedge clk_i) begin A_i = 4'd4; rd_i = 1'b1; end
        wait_cycles(5);
        rd_i = 1'b0;
        check("held read vector", D_o, 8'h80);
        bus_read(4'd1, rd);
        check("held read pend", rd, 8'h02);
        check("n_int before reset", {7'b0, n_int_o}, 8'h00);

        // Reset mid-operation
        @(negedge clk_i) reset_i = 1'b1;
        @(negedge clk_i) reset_i = 1'b0;
        check("midreset n_int", {7'b0, n_int_o}, 8'h01);
        check("midreset d_o", D_o, 8'h00);
        bus_read(4'd2, rd);
        check("midreset mask", rd, 8'h00);

`ifdef INTCTL_POLARITY_EN
        do_reset();
        bus_write(4'd5, 8'h01);
        bus_write(4'd2, 8'h01);
        wait_cycles(5);
        check("polarity n_int", {7'b0, n_int_o}, 8'h00);
        bus_read(4'd5, rd);
        check("polarity pol", rd, 8'h01);
`else
        do_reset();
        bus_write(4'd5, 8'hFF);
        bus_read(4'd5, rd);
        check("no polarity reg", rd, 8'h00);
        wait_cycles(4);
        check("no polarity n_int", {7'b0, n_int_o}, 8'h01);
`endif

        wait_cycles(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Parametrised interrupt controller for the support CPU. It sits on the support I/O bus in an 8-bit register window and collects up to 8 peripheral interrupt lines (UART, I2C, FDC, USB, ...). Each line has a per-line mask, a level/edge mode and, optionally, a polarity setting. The block drives a single registered active-low interrupt request to the tv80. It also provides a priority vector register whose read acknowledges the winning edge source.

## Interface
- NUM_LINES, 8: number of interrupt inputs, legal range 1..8. Register bits at index NUM_LINES and above read 0 and ignore writes.
- clk_i  in  1  bus clock; the only clock in the block.
- reset_i  in  1  reset; synchronous and active-high.
- irq_i  in  NUM_LINES  raw interrupt lines, asynchronous to clk_i.
- A_i  in  4  register address.
- D_i  in  8  write data.
- D_o  out  8  read data, registered.
- rd_i  in  1  read strobe, active-high, may be held for several cycles.
- wr_i  in  1  write strobe, active-high, may be held for several cycles.
- n_int_o  out  1  interrupt request to the CPU, active-low, registered.

## Operation
- Each line passes through a 2-flop synchroniser, giving s2. A third flop, s3, holds the previous value of s2 for edge detection.
- Active value: act = s2 XOR pol.
- Register map (any address not listed reads 0x00 and ignores writes):
  - 0 STATUS (RO): pend & mask.
  - 1 PEND: read returns raw pending. Writing 1 clears that bit; writing 0 has no effect.
  - 2 MASK (RW): 1 = enabled. Reset 0x00.
  - 3 MODE (RW): 1 = edge, 0 = level. Reset 0x00.
  - 4 VECTOR (RO): bit7 = valid, bits[2:0] = lowest-index line set in STATUS, bits[6:3] = 0. Reads 0x00 when STATUS is 0.
  - 5 POL (RW): 1 = active-low input. Reset 0x00. Present only with INTCTL_POLARITY_EN.
- Level mode: pend[i] is registered from act[i] every cycle. PEND writes have no lasting effect; the bit reloads on the next cycle.
- Edge mode: pend[i] is set on an act rising edge (act of s2 = 1, act of s3 = 0) and holds until cleared.
  - Clear sources: a PEND write-1, or a VECTOR read that selects line i.
  - Set and clear in the same cycle: set wins, so the bit stays 1.
- Changing MODE from edge to level: the bit follows act from the next cycle.
- Changing MODE from level to edge: the current pend value is kept until cleared.
- Changing POL can create a spurious edge. This is accepted; software clears PEND afterwards.
- n_int_o is registered: low when |(pend & mask), else high.
- Writes take effect once per strobe, on the rising edge of wr_i (wr_i & ~wr_q). A held wr_i does not rewrite.
- Read side effects (the VECTOR acknowledge) also fire only once, on the rising edge of rd_i.
- D_o is loaded on the rd_i rising edge and holds its value until the next read.

## Timing
- Reset (synchronous, one cycle is sufficient):
  - pend, mask, mode, pol and the sync/edge flops go to 0.
  - D_o = 0x00, n_int_o = 1.
  - The rd_q and wr_q edge-tracking flops go to 0.
- Reset asserted mid-operation: everything above is cleared on that edge. An interrupt already requested is dropped; n_int_o is high after that edge.
- Latency, with irq_i changing before edge E0:
  - s1 captures at E0, s2 at E1, pend at E2.
  - n_int_o is low after E3, i.e. 3 full cycles later.
- After the clearing edge Ec (a PEND write or VECTOR read), n_int_o is high after Ec+1, provided nothing else is pending.
- Read data: D_o is valid on the edge that sees rd_i rise, so data is available the following cycle. The VECTOR value captured is the value from before the acknowledge clear.
- Writes: the register holds the new value from the edge after the one that samples the wr_i rising edge.
- Priority is fixed: lowest index wins. Masked lines never appear in VECTOR.

## Configuration
- Macro: INTCTL_POLARITY_EN.
- Defined: the POL register at address 5 exists, and inputs are XORed with pol.
- Undefined:
  - No pol flops are built; all lines are active-high.
  - Address 5 reads 0x00 and writes are ignored.

## Test plan
- Level mode, no polarity: reset, MASK=0x01, irq_i[0] high at E0 -> n_int_o low after E3. STATUS reads 0x01. Drop irq_i[0] -> n_int_o high 3 cycles later.
- Edge priority: MODE=0xFF, MASK=0x0C, pulse irq_i[3] and irq_i[2] together.
  - First VECTOR read -> 0x82; second read -> 0x83; third read -> 0x00.
  - n_int_o goes high after the second acknowledge.
- Masked line: MASK=0x00, pulse irq_i[5] (edge mode) -> PEND=0x20, STATUS=0x00, n_int_o stays 1. Writing MASK=0x20 -> n_int_o low next cycle.
- Set/clear collision: edge mode on line 1, make a PEND write of 0x02 coincide with the cycle pend is set -> PEND reads 0x02 afterwards, n_int_o stays low.
- Held strobes and reset mid-operation:
  - rd_i held for 5 cycles on VECTOR -> only one line is acknowledged.
  - With n_int_o low, assert reset_i for 1 cycle -> n_int_o=1, MASK=0, D_o=0x00.
- Polarity (with INTCTL_POLARITY_EN): POL=0x01, MASK=0x01, level mode, irq_i[0]=0 -> n_int_o low. Without the macro, POL reads 0x00 after writing 0xFF.
